// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared state encoding, frame constants and bit helpers for the receive FCS checker
package eth_rx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_PREAMBLE = 2'd1;
  localparam state_t ST_DATA     = 2'd2;
  localparam state_t ST_DROP     = 2'd3;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  // The wire carries bytes LSB first; the CRC register shifts MSB first.
  function automatic logic [7:0] bitreverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_check_crc32.sv
// rtl/eth_rx_fcs_check_crc32.sv - byte-wise CRC-32 (0x04C11DB7) combinational update, MSB of data first
module eth_rx_fcs_check_crc32 (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  import eth_rx_pkg::*;

  logic [31:0] acc;

  always_comb begin
    acc = crc;
    for (int i = 7; i >= 0; i--) begin
      if (acc[31] ^ data[i]) begin
        acc = {acc[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        acc = {acc[30:0], 1'b0};
      end
    end
    crc_next = acc;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - GMII receive path: strips preamble/SFD, checks and strips the FCS,
// forwards payload with a last flag and keeps saturating good/error frame counters.
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rx_data,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             stat_valid,
  output logic             stat_crc_err,
  output logic             stat_len_err,
  output logic             stat_phy_err,
  output logic [10:0]      stat_len,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_crc,
  output logic [CNT_W-1:0] cnt_len
);
  import eth_rx_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [10:0]      LEN_MIN = 11'(MIN_LEN);
  localparam logic [10:0]      LEN_MAX = 11'(MAX_LEN);

  state_t          state;
  logic [31:0]     crc;
  logic [31:0]     crc_upd;
  logic [7:0]      rx_data_rev;
  logic [10:0]     count;
  logic [4:0][7:0] dline;
  logic            phy_seen;
  logic            dline_full;

  assign rx_data_rev = bitreverse8(rx_data);
  assign dline_full  = (count >= 11'd5);

  eth_rx_fcs_check_crc32 u_crc32 (
    .crc      (crc),
    .data     (rx_data_rev),
    .crc_next (crc_upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      crc          <= CRC_INIT;
      count        <= '0;
      dline        <= '0;
      phy_seen     <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      stat_valid   <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      stat_len     <= '0;
      cnt_ok       <= '0;
      cnt_crc      <= '0;
      cnt_len      <= '0;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      stat_valid <= 1'b0;

      // Counters follow the status strobe by one edge, using its registered flags.
      if (stat_valid) begin
        if (!stat_crc_err && !stat_len_err && !stat_phy_err && cnt_ok != '1) begin
          cnt_ok <= cnt_ok + CNT_ONE;
        end
        if (stat_crc_err && cnt_crc != '1) begin
          cnt_crc <= cnt_crc + CNT_ONE;
        end
        if (stat_len_err && cnt_len != '1) begin
          cnt_len <= cnt_len + CNT_ONE;
        end
      end

      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            state <= (rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
          end
        end

        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_data == SFD_BYTE) begin
            state    <= ST_DATA;
            crc      <= CRC_INIT;
            count    <= '0;
            phy_seen <= 1'b0;
          end else if (rx_data != PREAMBLE_BYTE) begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (!rx_dv) begin
            // The oldest buffered byte is the last payload byte; the other four are FCS.
            stat_valid   <= 1'b1;
            stat_crc_err <= (crc != CRC_RESIDUE);
            stat_len_err <= (count < LEN_MIN);
            stat_phy_err <= phy_seen;
            stat_len     <= count;
            if (dline_full) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= dline[4];
            end
            state <= ST_IDLE;
          end else if (count == LEN_MAX) begin
            stat_valid   <= 1'b1;
            stat_crc_err <= (crc != CRC_RESIDUE);
            stat_len_err <= 1'b1;
            stat_phy_err <= phy_seen | rx_er;
            stat_len     <= count + 11'd1;
            m_valid      <= 1'b1;
            m_last       <= 1'b1;
            m_data       <= dline[4];
            state        <= ST_DROP;
          end else begin
            crc      <= crc_upd;
            count    <= count + 11'd1;
            dline    <= {dline[3:0], rx_data};
            phy_seen <= phy_seen | rx_er;
            if (dline_full) begin
              m_valid <= 1'b1;
              m_data  <= dline[4];
            end
          end
        end

        ST_DROP: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb/tb_eth_rx_fcs_check.sv - scoreboard bench for eth_rx_fcs_check
`timescale 1ns/1ps
module tb_eth_rx_fcs_check;

  typedef struct packed {
    logic        crc;
    logic        len;
    logic        phy;
    logic [10:0] slen;
    logic        timed;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        stat_valid;
  logic        stat_crc_err;
  logic        stat_len_err;
  logic        stat_phy_err;
  logic [10:0] stat_len;
  logic [31:0] cnt_ok;
  logic [31:0] cnt_crc;
  logic [31:0] cnt_len;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  beat_q[$];
  stat_t       stat_q[$];
  logic [7:0]  pay[$];
  longint      exp_ok  = 0;
  longint      exp_crc = 0;
  longint      exp_len = 0;
  time         t_edge  = 0;

  eth_rx_fcs_check dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rx_data      (rx_data),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .stat_valid   (stat_valid),
    .stat_crc_err (stat_crc_err),
    .stat_len_err (stat_len_err),
    .stat_phy_err (stat_phy_err),
    .stat_len     (stat_len),
    .cnt_ok       (cnt_ok),
    .cnt_crc      (cnt_crc),
    .cnt_len      (cnt_len)
  );

  always #5 clk = ~clk;

  // Reflected (LSB-first) CRC-32 reference, independent of the DUT's MSB-first register.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_stat(input logic crc, input logic len, input logic phy,
                           input logic [10:0] slen, input logic timed);
    stat_t s;
    s.crc = crc; s.len = len; s.phy = phy; s.slen = slen; s.timed = timed;
    stat_q.push_back(s);
    if (!crc && !len && !phy) exp_ok++;
    if (crc) exp_crc++;
    if (len) exp_len++;
  endtask

  task automatic preamble();
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
  endtask

  // Sends pay[0..n_pay-1] plus a correct FCS; flip_idx corrupts one payload bit after the FCS is formed.
  task automatic send_frame(input int n_pay, input int flip_idx, input int er_idx, input int idle);
    logic [31:0] fcs;
    int          total;
    fcs = ~ref_crc(n_pay);
    if (flip_idx >= 0) pay[flip_idx] = pay[flip_idx] ^ 8'h08;
    total = n_pay + 4;
    for (int i = 0; i < n_pay; i++) beat_q.push_back({(i == n_pay - 1), pay[i]});
    push_stat(flip_idx >= 0, total < 64, er_idx >= 0, 11'(total), 1'b0);
    preamble();
    for (int i = 0; i < n_pay; i++) drive(1'b1, (i == er_idx), pay[i]);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, fcs[8*k +: 8]);
    repeat (idle) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_ok"},  cnt_ok,  exp_ok);
    check({tag, "_cnt_crc"}, cnt_crc, exp_crc);
    check({tag, "_cnt_len"}, cnt_len, exp_len);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1) begin
      checks++;
      if (beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", m_data, m_last);
      end else begin
        logic [8:0] e;
        e = beat_q.pop_front();
        if ({m_last, m_data} !== e) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b", m_data, m_last, e[7:0], e[8]);
        end
      end
    end
    if (rst_n === 1'b1 && stat_valid === 1'b1) begin
      checks++;
      if (stat_q.size() == 0) begin
        errors++;
        $display("FAIL stat_unexpected: got len=%0d, required no status", stat_len);
      end else begin
        stat_t s;
        s = stat_q.pop_front();
        if ({stat_crc_err, stat_len_err, stat_phy_err, stat_len} !== {s.crc, s.len, s.phy, s.slen}) begin
          errors++;
          $display("FAIL stat: got crc=%b len_err=%b phy=%b len=%0d, required crc=%b len_err=%b phy=%b len=%0d",
                   stat_crc_err, stat_len_err, stat_phy_err, stat_len, s.crc, s.len, s.phy, s.slen);
        end
        if (s.timed) begin
          checks++;
          if ($time != t_edge + 5) begin
            errors++;
            $display("FAIL stat_time: got %0t, required %0t", $time, t_edge + 5);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic crc_so_far;
    rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_stat_valid", stat_valid, 0);
    check("rst_stat_len", stat_len, 0);
    check_counters("rst");
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    fill(60, 8'h00);
    send_frame(60, -1, -1, 3);
    check_counters("good64");

    fill(60, 8'h00);
    send_frame(60, 10, -1, 3);
    check_counters("crc_flip");

    fill(36, 8'hA0);
    send_frame(36, -1, -1, 3);
    check_counters("runt40");

    fill(60, 8'h40);
    send_frame(60, -1, 20, 3);
    check_counters("phy_err");

    preamble_bad: begin
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD4);
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i));
      repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    check_counters("bad_sfd");

    fill(1518, 8'h00);
    crc_so_far = (ref_crc(1518) != 32'hDEBB20E3);
    for (int i = 0; i <= 1513; i++) beat_q.push_back({(i == 1513), 8'(i)});
    push_stat(crc_so_far, 1'b1, 1'b0, 11'd1519, 1'b1);
    preamble();
    for (int i = 0; i < 1600; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      if (i == 1518) t_edge = $time - 1;
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check_counters("oversize");

    fill(60, 8'h10);
    send_frame(60, -1, -1, 3);
    check_counters("after_oversize");

    fill(60, 8'h20);
    send_frame(60, -1, -1, 1);
    fill(46, 8'h80);
    send_frame(46, -1, -1, 1);
    preamble();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hE0 + 8'(i));
    check_counters("back_to_back");
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    exp_ok = 0; exp_crc = 0; exp_len = 0;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_stat_valid", stat_valid, 0);
    check_counters("midrst");
    drive(1'b0, 1'b0, 8'h00);

    fill(60, 8'h33);
    send_frame(60, -1, -1, 3);
    check_counters("after_reset");

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    check("beat_q_left", beat_q.size(), 0);
    check("stat_q_left", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
